// File: rtl/hf_pkg.sv
// Shared types for the nibble serialiser: FSM encodings, the FIFO entry
// layout {nibble[6:3], last[2], len[1:0]} and a helper that packs one.
package hf_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam int NIB_ENTRY_W = 7;

  localparam int ENT_NIB_MSB = 6;
  localparam int ENT_NIB_LSB = 3;
  localparam int ENT_LAST    = 2;
  localparam int ENT_LEN_MSB = 1;
  localparam int ENT_LEN_LSB = 0;

  typedef logic [NIB_ENTRY_W-1:0] nib_entry_t;

  function automatic nib_entry_t pack_entry(
    input logic [3:0] nib,
    input logic       last,
    input logic [1:0] len
  );
    nib_entry_t e;
    e = '0;
    e[ENT_NIB_MSB:ENT_NIB_LSB] = nib;
    e[ENT_LAST]                = last;
    e[ENT_LEN_MSB:ENT_LEN_LSB] = len;
    return e;
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// DEPTH x 7 synchronous FIFO with registered count and synchronous clear.
// Ports: CLK, Reset (async low), i_clr, i_push/i_din, i_pop/o_head,
// o_count, o_full, o_empty. Push when full / pop when empty are ignored.
module nibble_fifo
  import hf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [NIB_ENTRY_W-1:0] i_din,
  input  logic                   i_pop,
  output logic [NIB_ENTRY_W-1:0] o_head,
  output logic [CW-1:0]          o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  logic [NIB_ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wp;
  logic [AW-1:0]          r_rp;
  logic [CW-1:0]          r_cnt;
  logic                   w_push;
  logic                   w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rp];

  assign w_push = i_push && !o_full && !i_clr;
  assign w_pop  = i_pop && !o_empty && !i_clr;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

endmodule

// File: rtl/nibble_serial_ctrl.sv
// Nibble-in / bit-out serialiser: nibble FIFO feeding an LSB-first shifter.
// Ports: CLK, Reset (async low), nib_in*/nib_in_ready, flush, bit_out*,
// busy, stall_cnt. Macro NIBBLE_SERIAL_CTRL_STATS_EN enables stall_cnt.
module nibble_serial_ctrl
  import hf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [3:0]       nib_in,
  input  logic             nib_in_valid,
  input  logic             nib_in_last,
  input  logic [1:0]       nib_in_len,
  output logic             nib_in_ready,
  input  logic             flush,
  output logic             bit_out,
  output logic             bit_out_valid,
  output logic             bit_out_last,
  input  logic             bit_out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NIB_ENTRY_W-1:0] w_head;
  logic [CW-1:0]          w_count;
  logic                   w_full;
  logic                   w_empty;

  logic                   r_state;
  logic [NIB_ENTRY_W-1:0] r_ent;
  logic [1:0]             r_idx;

  logic [3:0] w_nib;
  logic       w_last;
  logic [1:0] w_len;
  logic       w_shift;
  logic       w_take;
  logic       w_final;
  logic       w_done;
  logic       w_load;
  logic       w_push;

  assign w_nib  = r_ent[ENT_NIB_MSB:ENT_NIB_LSB];
  assign w_last = r_ent[ENT_LAST];
  assign w_len  = r_ent[ENT_LEN_MSB:ENT_LEN_LSB];

  assign w_shift = (r_state == ST_SHIFT);
  assign w_take  = w_shift && bit_out_ready;
  assign w_final = (r_idx == 2'd3) || (w_last && (r_idx == w_len));
  assign w_done  = w_take && w_final;

  // Reload on the same edge the last bit leaves, so nibbles stream gap-free.
  assign w_load = !flush && !w_empty && (!w_shift || w_done);

  // Ready comes from the registered count only; a pop frees space next cycle.
  assign nib_in_ready = !w_full;
  assign w_push = nib_in_valid && nib_in_ready && !flush;

  nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .Reset   (Reset),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_din   (pack_entry(nib_in, nib_in_last, nib_in_len)),
    .i_pop   (w_load),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_ent   <= '0;
      r_idx   <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_ent   <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_state <= ST_SHIFT;
      r_ent   <= w_head;
      r_idx   <= '0;
    end else if (w_done) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else if (w_take) begin
      r_idx   <= r_idx + 1'b1;
    end
  end

  assign bit_out       = w_nib[r_idx];
  assign bit_out_valid = w_shift;
  assign bit_out_last  = w_shift && w_last && (r_idx == w_len);
  assign busy          = (w_count != '0) || w_shift;

`ifdef NIBBLE_SERIAL_CTRL_STATS_EN
  logic [CNT_W-1:0] r_stall;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      r_stall <= '0;
    else if (flush)
      r_stall <= '0;
    else if (w_shift && !bit_out_ready && (r_stall != '1))
      r_stall <= r_stall + 1'b1;
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nibble_serial_ctrl.sv
// Directed self-checking bench for nibble_serial_ctrl (DEPTH=4, CNT_W=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_nibble_serial_ctrl;

  logic       CLK;
  logic       Reset;
  logic [3:0] nib_in;
  logic       nib_in_valid;
  logic       nib_in_last;
  logic [1:0] nib_in_len;
  logic       nib_in_ready;
  logic       flush;
  logic       bit_out;
  logic       bit_out_valid;
  logic       bit_out_last;
  logic       bit_out_ready;
  logic       busy;
  logic [3:0] stall_cnt;

  int errors;
  int checks;

  nibble_serial_ctrl #(.DEPTH(4), .CNT_W(4)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .nib_in        (nib_in),
    .nib_in_valid  (nib_in_valid),
    .nib_in_last   (nib_in_last),
    .nib_in_len    (nib_in_len),
    .nib_in_ready  (nib_in_ready),
    .flush         (flush),
    .bit_out       (bit_out),
    .bit_out_valid (bit_out_valid),
    .bit_out_last  (bit_out_last),
    .bit_out_ready (bit_out_ready),
    .busy          (busy),
    .stall_cnt     (stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bit_out !== 1'b0 || bit_out_valid !== 1'b0 ||
        bit_out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got %b%b%b want 000",
               bit_out, bit_out_valid, bit_out_last);
    end
    checks++;
    if (busy !== 1'b0 || nib_in_ready !== 1'b1 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_status: busy=%b rdy=%b cnt=%0d want 0 1 0",
               busy, nib_in_ready, stall_cnt);
    end
    tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] exp_b;
    exp_b = 4'b1011;
    bit_out_ready = 1'b1;
    nib_in = 4'b1011;
    nib_in_last = 1'b0;
    nib_in_valid = 1'b1;
    tick();
    nib_in_valid = 1'b0;
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_lat: valid=%b busy=%b want 0 1",
               bit_out_valid, busy);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (bit_out_valid !== 1'b1 || bit_out !== exp_b[b] ||
          bit_out_last !== 1'b0) begin
        errors++;
        $display("FAIL single_bit%0d: v=%b d=%b l=%b want 1 %b 0",
                 b, bit_out_valid, bit_out, bit_out_last, exp_b[b]);
      end
      tick();
    end
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_end: valid=%b busy=%b want 0 0",
               bit_out_valid, busy);
    end
  endtask

  task automatic test_partial();
    logic [2:0] exp_d;
    logic [2:0] exp_l;
    exp_d = 3'b110;
    exp_l = 3'b100;
    bit_out_ready = 1'b1;
    nib_in = 4'b0110;
    nib_in_last = 1'b1;
    nib_in_len = 2'd2;
    nib_in_valid = 1'b1;
    tick();
    nib_in_valid = 1'b0;
    nib_in_last = 1'b0;
    nib_in_len = 2'd0;
    tick();
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (bit_out_valid !== 1'b1 || bit_out !== exp_d[b] ||
          bit_out_last !== exp_l[b]) begin
        errors++;
        $display("FAIL partial_bit%0d: v=%b d=%b l=%b want 1 %b %b",
                 b, bit_out_valid, bit_out, bit_out_last,
                 exp_d[b], exp_l[b]);
      end
      tick();
    end
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL partial_end: valid=%b busy=%b want 0 0",
               bit_out_valid, busy);
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0] v [6];
    logic [3:0] cur;
    int k;
    logic acc;
    v[0] = 4'h3; v[1] = 4'h5; v[2] = 4'hA;
    v[3] = 4'hC; v[4] = 4'h9; v[5] = 4'h6;
    bit_out_ready = 1'b0;
    k = 0;
    nib_in = v[0];
    nib_in_valid = 1'b1;
    cur = v[0];
    for (int c = 0; c < 8; c++) begin
      acc = nib_in_ready;
      tick();
      if (acc && k < 5) begin
        k++;
        nib_in = v[k];
      end
      if (bit_out_valid) begin
        checks++;
        if (bit_out !== cur[0]) begin
          errors++;
          $display("FAIL bp_hold c%0d: bit=%b want %b", c, bit_out, cur[0]);
        end
      end
    end
    nib_in_valid = 1'b0;
    checks++;
    if (k !== 5 || nib_in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: accepted=%0d rdy=%b busy=%b want 5 0 1",
               k, nib_in_ready, busy);
    end
    bit_out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cur = v[n];
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (bit_out_valid !== 1'b1 || bit_out !== cur[b]) begin
          errors++;
          $display("FAIL bp_drain n%0d b%0d: v=%b d=%b want 1 %b",
                   n, b, bit_out_valid, bit_out, cur[b]);
        end
        tick();
      end
    end
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: valid=%b busy=%b want 0 0",
               bit_out_valid, busy);
    end
  endtask

  task automatic test_streaming();
    logic [3:0] sv [8];
    sv[0] = 4'h1; sv[1] = 4'h2; sv[2] = 4'h4; sv[3] = 4'h8;
    sv[4] = 4'hE; sv[5] = 4'h7; sv[6] = 4'hB; sv[7] = 4'hD;
    bit_out_ready = 1'b1;
    fork
      begin
        int w;
        logic acc;
        for (int i = 0; i < 8; i++) begin
          nib_in = sv[i];
          nib_in_valid = 1'b1;
          acc = 1'b0;
          w = 0;
          while (!acc && w < 50) begin
            acc = nib_in_ready;
            tick();
            w++;
          end
          checks++;
          if (!acc) begin
            errors++;
            $display("FAIL stream_push%0d: accepted=0 want 1", i);
          end
        end
        nib_in_valid = 1'b0;
      end
      begin
        int w;
        logic [3:0] cur;
        w = 0;
        while (!bit_out_valid && w < 20) begin
          tick();
          w++;
        end
        checks++;
        if (!bit_out_valid) begin
          errors++;
          $display("FAIL stream_start: valid=0 want 1");
        end
        for (int n = 0; n < 8; n++) begin
          cur = sv[n];
          for (int b = 0; b < 4; b++) begin
            checks++;
            if (bit_out_valid !== 1'b1 || bit_out !== cur[b]) begin
              errors++;
              $display("FAIL stream n%0d b%0d: v=%b d=%b want 1 %b",
                       n, b, bit_out_valid, bit_out, cur[b]);
            end
            tick();
          end
        end
      end
    join
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: valid=%b busy=%b want 0 0",
               bit_out_valid, busy);
    end
  endtask

  task automatic test_flush();
    logic [3:0] a;
    a = 4'b0101;
    bit_out_ready = 1'b0;
    nib_in_valid = 1'b1;
    nib_in = a;
    tick();
    nib_in = 4'h6;
    tick();
    nib_in = 4'h9;
    tick();
    nib_in_valid = 1'b0;
    bit_out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bit_out_valid !== 1'b1 || bit_out !== a[2]) begin
      errors++;
      $display("FAIL flush_pre: v=%b d=%b want 1 %b",
               bit_out_valid, bit_out, a[2]);
    end
    flush = 1'b1;
    nib_in_valid = 1'b1;
    nib_in = 4'hF;
    tick();
    flush = 1'b0;
    nib_in_valid = 1'b0;
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b0 ||
        stall_cnt !== 4'd0 || nib_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_post: v=%b busy=%b cnt=%0d rdy=%b want 0 0 0 1",
               bit_out_valid, busy, stall_cnt, nib_in_ready);
    end
    tick();
    tick();
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_noaccept: v=%b busy=%b want 0 0",
               bit_out_valid, busy);
    end
  endtask

  task automatic test_stats();
    logic [3:0] e5;
    logic [3:0] e20;
`ifdef NIBBLE_SERIAL_CTRL_STATS_EN
    e5 = 4'd5;
    e20 = 4'd15;
`else
    e5 = 4'd0;
    e20 = 4'd0;
`endif
    bit_out_ready = 1'b0;
    nib_in = 4'h5;
    nib_in_valid = 1'b1;
    tick();
    nib_in_valid = 1'b0;
    tick();
    checks++;
    if (bit_out_valid !== 1'b1 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stats_start: v=%b cnt=%0d want 1 0",
               bit_out_valid, stall_cnt);
    end
    repeat (5) tick();
    checks++;
    if (stall_cnt !== e5) begin
      errors++;
      $display("FAIL stats_5: cnt=%0d want %0d", stall_cnt, e5);
    end
    repeat (15) tick();
    checks++;
    if (stall_cnt !== e20 || bit_out !== 1'b1) begin
      errors++;
      $display("FAIL stats_sat: cnt=%0d bit=%b want %0d 1",
               stall_cnt, bit_out, e20);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0 || bit_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stats_clr: cnt=%0d v=%b want 0 0",
               stall_cnt, bit_out_valid);
    end
    bit_out_ready = 1'b1;
  endtask

  task automatic test_reset_midstream();
    bit_out_ready = 1'b1;
    nib_in = 4'hF;
    nib_in_valid = 1'b1;
    tick();
    nib_in = 4'hB;
    tick();
    nib_in_valid = 1'b0;
    tick();
    checks++;
    if (bit_out_valid !== 1'b1 || bit_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: v=%b d=%b want 1 1", bit_out_valid, bit_out);
    end
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b0 || bit_out !== 1'b0 ||
        bit_out_last !== 1'b0 || nib_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: v=%b busy=%b d=%b l=%b rdy=%b want 0 0 0 0 1",
               bit_out_valid, busy, bit_out, bit_out_last, nib_in_ready);
    end
    tick();
    tick();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bit_out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: v=%b busy=%b want 0 0",
               bit_out_valid, busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    Reset = 1'b0;
    nib_in = 4'h0;
    nib_in_valid = 1'b0;
    nib_in_last = 1'b0;
    nib_in_len = 2'd0;
    flush = 1'b0;
    bit_out_ready = 1'b0;
    test_reset();
    test_single();
    test_partial();
    test_back_pressure();
    test_streaming();
    test_flush();
    test_stats();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
